// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: arbitrates ALU and load writers onto the register
// file write port and keeps a per-register pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  input  logic [ADDRESS_WIDTH-1:0] iss_rd,
  output logic                     iss_ready,
  input  logic [ADDRESS_WIDTH-1:0] ad1,
  input  logic [ADDRESS_WIDTH-1:0] ad2,
  output logic                     raw_stall,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDRESS_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     mem_ready,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic [DATA_WIDTH-1:0]    wd3,
  output logic                     idle
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;

  logic [NREG-1:0]          busy_q, busy_d;
  logic [3:0]               starve_q, starve_d;
  logic                     we3_q;
  logic [ADDRESS_WIDTH-1:0] ad3_q;
  logic [DATA_WIDTH-1:0]    wd3_q;

  logic                     alu_win;
  logic                     xfer;
  logic [ADDRESS_WIDTH-1:0] wr_rd;
  logic [DATA_WIDTH-1:0]    wr_data;

  assign iss_ready = !busy_q[iss_rd];
  assign raw_stall = busy_q[ad1] | busy_q[ad2];
  assign idle      = !(|busy_q) && !we3_q;

  // Grants look only at valids and starve so no path exists from rd/data to ready.
  assign alu_win   = alu_valid && (!mem_valid || (starve_q == 4'(STARVE_LIMIT)));
  assign alu_ready = alu_win;
  assign mem_ready = mem_valid && !alu_win;

  assign xfer    = alu_ready | mem_ready;
  assign wr_rd   = alu_ready ? alu_rd   : mem_rd;
  assign wr_data = alu_ready ? alu_data : mem_data;

  // NOTE: combinational blocks use blocking '=' with a default first so the
  // later set overrides the earlier clear and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (we3_q) busy_d[ad3_q] = 1'b0;
    if (iss_valid && iss_ready && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    if (!alu_valid || alu_ready) begin
      starve_d = '0;
    end else if (mem_valid && mem_ready && (starve_q < 4'(STARVE_LIMIT))) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      starve_q <= '0;
      we3_q    <= 1'b0;
      ad3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
      we3_q    <= xfer && (wr_rd != '0);
      if (xfer) begin
        ad3_q <= wr_rd;
        wd3_q <= wr_data;
      end
    end
  end

  assign we3 = we3_q;
  assign ad3 = ad3_q;
  assign wd3 = wd3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected write-port beats are queued
// when a request is driven and popped when the write stage should show them.
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  ad;
    logic [31:0] wd;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  ad1, ad2;
  logic        raw_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        we3;
  logic [4:0]  ad3;
  logic [31:0] wd3;
  logic        idle;

  int n_cmp  = 0;
  int n_fail = 0;
  wr_t exp_q[$];
  logic [4:0]  last_ad;
  logic [31:0] last_wd;

  regfile_wb_arbiter #(
    .ADDRESS_WIDTH(5),
    .DATA_WIDTH(32),
    .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .ad1(ad1), .ad2(ad2), .raw_stall(raw_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .we3(we3), .ad3(ad3), .wd3(wd3), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check grants, queue the expected write beat, step, compare the port.
  task automatic cycle(input logic exp_alu, input logic exp_mem);
    wr_t e;
    #1;
    check("alu_ready", {31'd0, alu_ready}, {31'd0, exp_alu});
    check("mem_ready", {31'd0, mem_ready}, {31'd0, exp_mem});
    if (exp_alu)      e = '{we: (alu_rd != 5'd0), ad: alu_rd, wd: alu_data};
    else if (exp_mem) e = '{we: (mem_rd != 5'd0), ad: mem_rd, wd: mem_data};
    else              e = '{we: 1'b0, ad: last_ad, wd: last_wd};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    last_ad = e.ad;
    last_wd = e.wd;
    check("we3", {31'd0, we3}, {31'd0, e.we});
    check("ad3", {27'd0, ad3}, {27'd0, e.ad});
    check("wd3", wd3, e.wd);
  endtask

  initial begin
    rst = 1'b1;
    iss_valid = 1'b0; iss_rd = '0; ad1 = '0; ad2 = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    last_ad = '0; last_wd = '0;
    #2;
    check("rst_we3", {31'd0, we3}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    check("rst_raw_stall", {31'd0, raw_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // RAW: issue rd=10, then ALU writes 10; ad1=10 stalls until after the commit edge.
    iss_valid = 1'b1; iss_rd = 5'd10;
    #1 check("raw_iss_ready", {31'd0, iss_ready}, 32'd1);
    cycle(1'b0, 1'b0);
    iss_valid = 1'b0;
    ad1 = 5'd10;
    #1 check("raw_stall_busy", {31'd0, raw_stall}, 32'd1);
    check("raw_not_idle", {31'd0, idle}, 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hDEADBEEF;
    cycle(1'b1, 1'b0);
    alu_valid = 1'b0;
    #1 check("raw_stall_at_we3", {31'd0, raw_stall}, 32'd1);
    cycle(1'b0, 1'b0);
    #1 check("raw_stall_cleared", {31'd0, raw_stall}, 32'd0);
    check("raw_idle", {31'd0, idle}, 32'd1);
    ad1 = '0;

    // Starvation: both valid -> mem,mem,mem,alu repeating.
    alu_valid = 1'b1; alu_rd = 5'd1;
    mem_valid = 1'b1; mem_rd = 5'd2;
    for (int i = 0; i < 8; i++) begin
      alu_data = 32'hA000_0000 + 32'(i);
      mem_data = 32'hB000_0000 + 32'(i);
      cycle((i % 4) == 3, (i % 4) != 3);
    end
    // mem only: mem every cycle, starve must not build up.
    alu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_data = 32'hC000_0000 + 32'(i);
      cycle(1'b0, 1'b1);
    end
    alu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'hD000_0000 + 32'(i);
      mem_data = 32'hE000_0000 + 32'(i);
      cycle(i == 3, i != 3);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // x0 write is granted but never enables the register file.
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_0055;
    cycle(1'b0, 1'b1);
    mem_valid = 1'b0;

    // WAW: second issue to 7 is held until the write to 7 commits.
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1 check("waw_first_ready", {31'd0, iss_ready}, 32'd1);
    cycle(1'b0, 1'b0);
    #1 check("waw_second_ready", {31'd0, iss_ready}, 32'd0);
    cycle(1'b0, 1'b0);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h0000_0077;
    #1 check("waw_still_busy", {31'd0, iss_ready}, 32'd0);
    cycle(1'b0, 1'b1);
    mem_valid = 1'b0;
    #1 check("waw_during_commit", {31'd0, iss_ready}, 32'd0);
    cycle(1'b0, 1'b0);
    #1 check("waw_after_commit", {31'd0, iss_ready}, 32'd1);
    iss_valid = 1'b0;

    // Set/clear collision on register 4: the issue set wins.
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_0444;
    cycle(1'b1, 1'b0);
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd4;
    #1 check("coll_iss_ready", {31'd0, iss_ready}, 32'd1);
    cycle(1'b0, 1'b0);
    iss_valid = 1'b0;
    ad2 = 5'd4;
    #1 check("coll_raw_stall", {31'd0, raw_stall}, 32'd1);
    cycle(1'b0, 1'b0);
    #1 check("coll_raw_stall_hold", {31'd0, raw_stall}, 32'd1);
    ad2 = '0;

    // Reset mid-stream with busy[5]=1 and we3=1.
    iss_valid = 1'b1; iss_rd = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0999;
    cycle(1'b1, 1'b0);
    iss_valid = 1'b0; alu_valid = 1'b0;
    ad1 = 5'd5;
    #1 check("pre_rst_raw_stall", {31'd0, raw_stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_we3", {31'd0, we3}, 32'd0);
    check("mid_rst_ad3", {27'd0, ad3}, 32'd0);
    check("mid_rst_wd3", wd3, 32'd0);
    check("mid_rst_idle", {31'd0, idle}, 32'd1);
    check("mid_rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    last_ad = '0; last_wd = '0;
    #1 check("post_rst_raw_stall", {31'd0, raw_stall}, 32'd0);
    cycle(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
